mac_scheduler: RTL and testbench
================================

Name: mac_scheduler

Overview:
- Shares one MAC unit between NUM_REQ requesters in the endmember-extraction datapath, e.g. the m1 distance path and the endmember-memory distance path.
- Each requester job is one SPECTRAL_BANDS-long vector accumulation. The scheduler arbitrates round-robin and locks the grant for the whole job.
- It forwards operands to the MAC and counts the MAC results. It returns the final accumulated value to the owner, then clears the MAC with a one-cycle mac_reset.

Parameters:
- SPECTRAL_BANDS, 100, elements per job.
- MAC_WIDTH, 36, operand and result width.
- NUM_REQ, 2, number of requesters (>=2).

Ports:
- clk  in  1  clock
- rst  in  1  reset
- req  in  NUM_REQ  per-requester job request; held high until the matching done
- op_a  in  NUM_REQ*MAC_WIDTH  flattened operand A; requester k at bits [k*MAC_WIDTH +: MAC_WIDTH]
- op_b  in  NUM_REQ*MAC_WIDTH  flattened operand B, same packing
- op_valid  in  NUM_REQ  element valid per requester
- op_ready  out  NUM_REQ  element accept per requester
- grant  out  NUM_REQ  one-hot owner of the MAC
- mac_out_1  out  MAC_WIDTH  operand A to MAC
- mac_out_2  out  MAC_WIDTH  operand B to MAC
- mac_valid_out  out  1  operand strobe to MAC
- mac_reset  out  1  MAC accumulator clear, one-cycle pulse
- mac_in  in  MAC_WIDTH  MAC accumulated value
- mac_valid_in  in  1  MAC result strobe, one per operand
- result_data  out  MAC_WIDTH  final accumulation of the last job
- done  out  NUM_REQ  one-cycle one-hot completion pulse
- busy  out  1  a job is in progress

Behaviour:
- Reset: rst is synchronous and active-high; clock is clk.
  - All outputs reset to 0.
  - rr_ptr resets so requester 0 has highest priority.
  - State resets to CLR.
  - rst mid-job aborts the job. No done is issued; the next state is CLR.
- CLR:
  - mac_reset=1 for exactly one cycle.
  - Then goes to IDLE.
- IDLE:
  - If any req bit is set, the winner is chosen round-robin: the first set bit at or after rr_ptr, wrapping around.
  - At the next edge: grant=onehot(winner), busy=1, state goes to STREAM, in_cnt=0, out_cnt=0.
  - Latency is one cycle from req to grant.
  - With no req, the scheduler stays in IDLE with grant=0.
- STREAM:
  - op_ready[k] = grant[k] while in_cnt < SPECTRAL_BANDS; combinational from registered state.
  - Accept condition: op_valid[k] & op_ready[k] for the owner k.
  - On accept: next cycle mac_out_1/mac_out_2 hold that requester's op_a/op_b, mac_valid_out=1, and in_cnt increments.
  - Operand latency is exactly one cycle. mac_out holds its last value when not strobed.
  - Non-owner op_valid is ignored.
  - When in_cnt reaches SPECTRAL_BANDS, state goes to DRAIN.
- out_cnt rule (any busy state): counts mac_valid_in pulses.
  - On the SPECTRAL_BANDS-th pulse: result_data<=mac_in, done[owner]<=1 for one cycle, grant<=0, busy<=0, rr_ptr<=owner+1 (mod NUM_REQ), state goes to CLR.
  - This can happen in STREAM on the same cycle the last operand is sent only if the MAC has zero latency. It is legal and takes priority over the move to DRAIN.
- DRAIN: op_ready=0; waits for the remaining mac_valid_in pulses.
- Ignored inputs:
  - mac_valid_in in IDLE or CLR.
  - mac_valid_in beyond SPECTRAL_BANDS.
- Protocol violations:
  - req dropped mid-job: the job still completes and done is still pulsed.
  - A requester whose req is still high in IDLE after its own done is eligible again, but at lowest priority.
- Counter widths: in_cnt and out_cnt are $clog2(SPECTRAL_BANDS)+1 bits. Both are cleared on grant.
- Arithmetic: operands pass through unmodified. No sign handling is done here.

Decomposition:
- Shared package (hsi_pkg):
  - state encodings CLR=0, IDLE=1, STREAM=2, DRAIN=3
  - MAC_WIDTH and SPECTRAL_BANDS defaults
- Sub-module rr_arbiter, combinational: (req, rr_ptr) -> one-hot winner plus index. It is reusable for the memory-port sharing.
- The FSM, counters and operand mux stay in mac_scheduler.

Test Plan (SPECTRAL_BANDS=4, NUM_REQ=2, MAC modelled as 1-cycle accumulator):
- Release rst -> mac_reset high exactly the cycle after reset drops, then IDLE with grant=00.
- req=01, requester 0 streams a=1,2,3,4 and b=1 -> grant=01 one cycle after req, four mac_valid_out with mac_out_1=1..4, done=01 pulse, result_data=10, one mac_reset pulse.
- req=11 from reset -> requester 0 served first, then requester 1. The second job's op_ready[0]=0 throughout. done order 01 then 10.
- op_valid toggled every other cycle by the owner -> in_cnt advances only on accepts, result is still correct, and op_ready drops after the 4th accept.
- MAC returns results with 3-cycle delay -> state DRAIN for 3 cycles, done only after the 4th mac_valid_in, and a spurious 5th mac_valid_in is ignored.
- rst asserted after 2 operands -> no done, grant=00, mac_reset pulse after release, and a new req is granted normally.

Source files
------------

// File: rtl/hsi_pkg.sv
// Shared types and defaults for the endmember-extraction datapath.
package hsi_pkg;

  localparam int unsigned MAC_WIDTH_DEFAULT      = 36;
  localparam int unsigned SPECTRAL_BANDS_DEFAULT = 100;

  typedef enum logic [1:0] {
    StClr    = 2'd0,
    StIdle   = 2'd1,
    StStream = 2'd2,
    StDrain  = 2'd3
  } sched_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or after i_rr_ptr, wrapping.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0]         i_req,
  input  logic [$clog2(NUM_REQ)-1:0] i_rr_ptr,
  output logic [NUM_REQ-1:0]         o_grant,
  output logic [$clog2(NUM_REQ)-1:0] o_idx,
  output logic                       o_valid
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  logic [IDX_W-1:0] w_cand;
  logic             w_found;

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    w_found = 1'b0;
    w_cand  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      w_cand = IDX_W'((32'(i_rr_ptr) + i) % NUM_REQ);
      if (!w_found && i_req[w_cand]) begin
        w_found         = 1'b1;
        o_idx           = w_cand;
        o_grant[w_cand] = 1'b1;
      end
    end
    o_valid = w_found;
  end

endmodule

// File: rtl/mac_scheduler.sv
// Shares one MAC between NUM_REQ requesters; grant is locked for a whole
// SPECTRAL_BANDS-long accumulation, then the MAC is cleared with a one-cycle pulse.
module mac_scheduler
  import hsi_pkg::*;
#(
  parameter int unsigned SPECTRAL_BANDS = SPECTRAL_BANDS_DEFAULT,
  parameter int unsigned MAC_WIDTH      = MAC_WIDTH_DEFAULT,
  parameter int unsigned NUM_REQ        = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           i_req,
  input  logic [NUM_REQ*MAC_WIDTH-1:0] i_op_a,
  input  logic [NUM_REQ*MAC_WIDTH-1:0] i_op_b,
  input  logic [NUM_REQ-1:0]           i_op_valid,
  output logic [NUM_REQ-1:0]           o_op_ready,
  output logic [NUM_REQ-1:0]           o_grant,
  output logic [MAC_WIDTH-1:0]         o_mac_out_1,
  output logic [MAC_WIDTH-1:0]         o_mac_out_2,
  output logic                         o_mac_valid_out,
  output logic                         o_mac_reset,
  input  logic [MAC_WIDTH-1:0]         i_mac_in,
  input  logic                         i_mac_valid_in,
  output logic [MAC_WIDTH-1:0]         o_result_data,
  output logic [NUM_REQ-1:0]           o_done,
  output logic                         o_busy
);

  localparam int unsigned      CNT_W    = $clog2(SPECTRAL_BANDS) + 1;
  localparam int unsigned      IDX_W    = $clog2(NUM_REQ);
  localparam logic [CNT_W-1:0] BANDS    = CNT_W'(SPECTRAL_BANDS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

  sched_state_e     r_state, w_state_d;
  logic [NUM_REQ-1:0] r_grant, w_grant_d;
  logic [NUM_REQ-1:0] r_done, w_done_d;
  logic [IDX_W-1:0] r_owner, w_owner_d;
  logic [IDX_W-1:0] r_rr_ptr, w_rr_ptr_d;
  logic             r_busy, w_busy_d;
  logic [CNT_W-1:0] r_in_cnt, w_in_cnt_d;
  logic [CNT_W-1:0] r_out_cnt, w_out_cnt_d;
  logic [MAC_WIDTH-1:0] r_mac_out_1, w_mac_out_1_d;
  logic [MAC_WIDTH-1:0] r_mac_out_2, w_mac_out_2_d;
  logic             r_mac_valid_out, w_mac_valid_out_d;
  logic [MAC_WIDTH-1:0] r_result, w_result_d;
  // Holds CLR for one cycle after rst so mac_reset pulses only once reset is released.
  logic             r_in_rst;

  logic [NUM_REQ-1:0] w_arb_grant;
  logic [IDX_W-1:0]   w_arb_idx;
  logic               w_arb_valid;
  logic               w_accept;
  logic               w_job_active;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_arbiter (
    .i_req    (i_req),
    .i_rr_ptr (r_rr_ptr),
    .o_grant  (w_arb_grant),
    .o_idx    (w_arb_idx),
    .o_valid  (w_arb_valid)
  );

  assign o_op_ready = ((r_state == StStream) && (r_in_cnt < BANDS)) ? r_grant : '0;
  assign w_accept   = |(i_op_valid & o_op_ready);
  assign w_job_active = (r_state == StStream) || (r_state == StDrain);

  always_comb begin
    w_state_d         = r_state;
    w_grant_d         = r_grant;
    w_owner_d         = r_owner;
    w_rr_ptr_d        = r_rr_ptr;
    w_busy_d          = r_busy;
    w_in_cnt_d        = r_in_cnt;
    w_out_cnt_d       = r_out_cnt;
    w_mac_out_1_d     = r_mac_out_1;
    w_mac_out_2_d     = r_mac_out_2;
    w_mac_valid_out_d = 1'b0;
    w_result_d        = r_result;
    w_done_d          = '0;

    case (r_state)
      StClr: begin
        if (!r_in_rst) w_state_d = StIdle;
      end
      StIdle: begin
        if (w_arb_valid) begin
          w_grant_d   = w_arb_grant;
          w_owner_d   = w_arb_idx;
          w_busy_d    = 1'b1;
          w_in_cnt_d  = '0;
          w_out_cnt_d = '0;
          w_state_d   = StStream;
        end
      end
      StStream: begin
        if (w_accept) begin
          w_mac_out_1_d     = i_op_a[r_owner*MAC_WIDTH +: MAC_WIDTH];
          w_mac_out_2_d     = i_op_b[r_owner*MAC_WIDTH +: MAC_WIDTH];
          w_mac_valid_out_d = 1'b1;
          w_in_cnt_d        = r_in_cnt + CNT_W'(1);
        end
        if (r_in_cnt == BANDS) w_state_d = StDrain;
      end
      default: ;
    endcase

    // The final MAC result closes the job from either busy state, overriding the DRAIN move.
    if (w_job_active && i_mac_valid_in && (r_out_cnt < BANDS)) begin
      w_out_cnt_d = r_out_cnt + CNT_W'(1);
      if (w_out_cnt_d == BANDS) begin
        w_result_d = i_mac_in;
        w_done_d   = r_grant;
        w_grant_d  = '0;
        w_busy_d   = 1'b0;
        w_rr_ptr_d = (r_owner == LAST_IDX) ? '0 : r_owner + IDX_W'(1);
        w_state_d  = StClr;
      end
    end
  end

  always_ff @(posedge clk) begin
    r_in_rst <= rst;
    if (rst) begin
      r_state         <= StClr;
      r_grant         <= '0;
      r_owner         <= '0;
      r_rr_ptr        <= '0;
      r_busy          <= 1'b0;
      r_in_cnt        <= '0;
      r_out_cnt       <= '0;
      r_mac_out_1     <= '0;
      r_mac_out_2     <= '0;
      r_mac_valid_out <= 1'b0;
      r_result        <= '0;
      r_done          <= '0;
    end else begin
      r_state         <= w_state_d;
      r_grant         <= w_grant_d;
      r_owner         <= w_owner_d;
      r_rr_ptr        <= w_rr_ptr_d;
      r_busy          <= w_busy_d;
      r_in_cnt        <= w_in_cnt_d;
      r_out_cnt       <= w_out_cnt_d;
      r_mac_out_1     <= w_mac_out_1_d;
      r_mac_out_2     <= w_mac_out_2_d;
      r_mac_valid_out <= w_mac_valid_out_d;
      r_result        <= w_result_d;
      r_done          <= w_done_d;
    end
  end

  assign o_grant         = r_grant;
  assign o_busy          = r_busy;
  assign o_mac_out_1     = r_mac_out_1;
  assign o_mac_out_2     = r_mac_out_2;
  assign o_mac_valid_out = r_mac_valid_out;
  assign o_result_data   = r_result;
  assign o_done          = r_done;
  assign o_mac_reset     = (r_state == StClr) && !r_in_rst;

endmodule

// File: tb/tb_mac_scheduler.sv
// Directed bench for mac_scheduler with SPECTRAL_BANDS=4, two requesters and a
// behavioural accumulating MAC whose result latency is selectable.
module tb_mac_scheduler;

  localparam int unsigned BANDS = 4;
  localparam int unsigned W     = 36;
  localparam int unsigned NR    = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [NR-1:0]   req;
  logic [NR*W-1:0] op_a, op_b;
  logic [NR-1:0]   op_valid, op_ready, grant, done;
  logic [W-1:0]    mac_out_1, mac_out_2, mac_in, result_data;
  logic            mac_valid_out, mac_reset, mac_valid_in, busy;

  int vec_cnt = 0;
  int err_cnt = 0;

  always #5 clk = ~clk;

  mac_scheduler #(
    .SPECTRAL_BANDS (BANDS),
    .MAC_WIDTH      (W),
    .NUM_REQ        (NR)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .i_req           (req),
    .i_op_a          (op_a),
    .i_op_b          (op_b),
    .i_op_valid      (op_valid),
    .o_op_ready      (op_ready),
    .o_grant         (grant),
    .o_mac_out_1     (mac_out_1),
    .o_mac_out_2     (mac_out_2),
    .o_mac_valid_out (mac_valid_out),
    .o_mac_reset     (mac_reset),
    .i_mac_in        (mac_in),
    .i_mac_valid_in  (mac_valid_in),
    .o_result_data   (result_data),
    .o_done          (done),
    .o_busy          (busy)
  );

  // Accumulating MAC with a result pipeline of mac_lat cycles; spur injects stray strobes.
  logic [W-1:0] mac_acc = '0;
  logic [W-1:0] acc_next;
  logic [3:0]   vpipe = '0;
  logic [W-1:0] dpipe [4];
  int           mac_lat = 1;
  logic         spur = 1'b0;

  assign acc_next = mac_acc + W'(mac_out_1 * mac_out_2);

  always @(posedge clk) begin
    if (mac_reset) mac_acc <= '0;
    else if (mac_valid_out) mac_acc <= acc_next;
    vpipe    <= {vpipe[2:0], mac_valid_out & ~mac_reset};
    dpipe[0] <= acc_next;
    dpipe[1] <= dpipe[0];
    dpipe[2] <= dpipe[1];
    dpipe[3] <= dpipe[2];
  end

  assign mac_valid_in = vpipe[mac_lat-1] | spur;
  assign mac_in       = dpipe[mac_lat-1];

  task automatic do_reset();
    rst = 1'b1; req = '0; op_valid = '0; op_a = '0; op_b = '0; spur = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; req = '0; op_valid = '0; op_a = '0; op_b = '0; spur = 1'b0;
    repeat (3) @(negedge clk);
    vec_cnt++;
    if ({grant, done, op_ready, busy, mac_valid_out, mac_reset} !== '0) begin
      err_cnt++;
      $display("FAIL reset_ctrl: got %b expected 0", {grant, done, op_ready, busy, mac_valid_out, mac_reset});
    end
    vec_cnt++;
    if ({result_data, mac_out_1, mac_out_2} !== '0) begin
      err_cnt++;
      $display("FAIL reset_data: got %h expected 0", {result_data, mac_out_1, mac_out_2});
    end
    rst = 1'b0;
    @(negedge clk);
    vec_cnt++;
    if (mac_reset !== 1'b1) begin
      err_cnt++; $display("FAIL reset_clr_pulse: got %b expected 1", mac_reset);
    end
    @(negedge clk);
    vec_cnt++;
    if (mac_reset !== 1'b0) begin
      err_cnt++; $display("FAIL reset_clr_width: got %b expected 0", mac_reset);
    end
    repeat (2) @(negedge clk);
    vec_cnt++;
    if ({grant, busy} !== 3'b000) begin
      err_cnt++; $display("FAIL reset_idle: got %b expected 000", {grant, busy});
    end
  endtask

  task automatic test_single_job();
    int n;
    req = 2'b01;
    @(negedge clk);
    vec_cnt++;
    if ({grant, busy} !== 3'b011) begin
      err_cnt++; $display("FAIL single_grant: got %b expected 011", {grant, busy});
    end
    for (int i = 0; i < 4; i++) begin
      op_a[0 +: W] = W'(i + 1); op_b[0 +: W] = W'(1); op_valid = 2'b01;
      @(negedge clk);
      vec_cnt++;
      if ({mac_valid_out, mac_out_1, mac_out_2} !== {1'b1, W'(i + 1), W'(1)}) begin
        err_cnt++;
        $display("FAIL single_op%0d: got %b/%0d/%0d expected 1/%0d/1", i, mac_valid_out,
                 mac_out_1, mac_out_2, i + 1);
      end
    end
    op_valid = '0;
    vec_cnt++;
    if (op_ready !== 2'b00) begin
      err_cnt++; $display("FAIL single_ready_drop: got %b expected 00", op_ready);
    end
    n = 0;
    while (done == '0 && n < 20) begin @(negedge clk); n++; end
    vec_cnt++;
    if ({done, grant, mac_reset} !== 5'b01_00_1 || n !== 2) begin
      err_cnt++;
      $display("FAIL single_done: got done=%b grant=%b mac_reset=%b wait=%0d expected 01/00/1/2",
               done, grant, mac_reset, n);
    end
    vec_cnt++;
    if (result_data !== W'(10)) begin
      err_cnt++; $display("FAIL single_result: got %0d expected 10", result_data);
    end
    req = '0;
    @(negedge clk);
    vec_cnt++;
    if ({done, mac_reset} !== 3'b000) begin
      err_cnt++; $display("FAIL single_pulses: got %b expected 000", {done, mac_reset});
    end
  endtask

  // Requester 0 keeps req high after its done, so it must yield to requester 1.
  task automatic test_two_req();
    int         idx [2];
    logic [1:0] drv, rdy, d1, d2;
    logic [W-1:0] r1, r2;
    int         ndone;
    bit         rdy0_bad;
    idx = '{0, 0}; drv = '0; rdy = '0; d1 = '0; d2 = '0; r1 = '0; r2 = '0;
    ndone = 0; rdy0_bad = 1'b0;
    do_reset();
    req = 2'b11;
    @(negedge clk);
    vec_cnt++;
    if (grant !== 2'b01) begin
      err_cnt++; $display("FAIL two_first_grant: got %b expected 01", grant);
    end
    for (int c = 0; c < 80 && ndone < 2; c++) begin
      for (int k = 0; k < 2; k++) if (drv[k] && rdy[k]) idx[k]++;
      if (done != '0) begin
        if (ndone == 0) begin d1 = done; r1 = result_data; end
        else begin d2 = done; r2 = result_data; end
        ndone++;
      end
      if (ndone == 2) req = '0;
      if (grant == 2'b10 && op_ready[0]) rdy0_bad = 1'b1;
      for (int k = 0; k < 2; k++) drv[k] = req[k] && (idx[k] < 4);
      op_a[0 +: W] = W'(1);          op_b[0 +: W] = W'(5);
      op_a[W +: W] = W'(idx[1] + 1); op_b[W +: W] = W'(3);
      op_valid = drv;
      rdy = op_ready;
      @(negedge clk);
    end
    op_valid = '0;
    vec_cnt++;
    if (d1 !== 2'b01 || r1 !== W'(20)) begin
      err_cnt++; $display("FAIL two_job0: got done=%b result=%0d expected 01/20", d1, r1);
    end
    vec_cnt++;
    if (d2 !== 2'b10 || r2 !== W'(30)) begin
      err_cnt++; $display("FAIL two_job1: got done=%b result=%0d expected 10/30", d2, r2);
    end
    vec_cnt++;
    if (rdy0_bad !== 1'b0) begin
      err_cnt++; $display("FAIL two_ready0_in_job1: got %b expected 0", rdy0_bad);
    end
  endtask

  task automatic test_toggle();
    logic [W-1:0] ta [4];
    int           acc_cnt, n;
    logic         rdy_snap;
    ta = '{W'(3), W'(4), W'(5), W'(6)};
    acc_cnt = 0;
    req = 2'b01;
    @(negedge clk);
    vec_cnt++;
    if (grant !== 2'b01) begin
      err_cnt++; $display("FAIL toggle_grant: got %b expected 01", grant);
    end
    for (int c = 0; c < 40 && acc_cnt < 4; c++) begin
      op_valid     = {1'b0, (c % 2) == 0};
      op_a[0 +: W] = ta[acc_cnt];
      op_b[0 +: W] = W'(2);
      rdy_snap     = op_ready[0];
      @(negedge clk);
      vec_cnt++;
      if (op_valid[0] && rdy_snap) begin
        acc_cnt++;
        if ({mac_valid_out, mac_out_1} !== {1'b1, ta[acc_cnt-1]}) begin
          err_cnt++;
          $display("FAIL toggle_op%0d: got %b/%0d expected 1/%0d", acc_cnt - 1, mac_valid_out,
                   mac_out_1, ta[acc_cnt-1]);
        end
      end else if (mac_valid_out !== 1'b0) begin
        err_cnt++; $display("FAIL toggle_idle_strobe: got %b expected 0", mac_valid_out);
      end
    end
    op_valid = '0;
    vec_cnt++;
    if (op_ready !== 2'b00 || acc_cnt !== 4) begin
      err_cnt++;
      $display("FAIL toggle_ready_drop: got ready=%b accepts=%0d expected 00/4", op_ready, acc_cnt);
    end
    n = 0;
    while (done == '0 && n < 20) begin @(negedge clk); n++; end
    vec_cnt++;
    if (done !== 2'b01 || result_data !== W'(36)) begin
      err_cnt++;
      $display("FAIL toggle_done: got done=%b result=%0d expected 01/36", done, result_data);
    end
    req = '0;
    @(negedge clk);
  endtask

  task automatic test_drain();
    int n;
    mac_lat = 3;
    req = 2'b10;
    @(negedge clk);
    vec_cnt++;
    if (grant !== 2'b10) begin
      err_cnt++; $display("FAIL drain_grant: got %b expected 10", grant);
    end
    for (int i = 0; i < 4; i++) begin
      op_a[W +: W] = W'(i + 1); op_b[W +: W] = W'(2); op_valid = 2'b10;
      @(negedge clk);
    end
    op_valid = '0;
    n = 0;
    while (done == '0 && n < 20) begin
      @(negedge clk); n++;
    end
    vec_cnt++;
    if (done !== 2'b10 || n !== 4) begin
      err_cnt++; $display("FAIL drain_done: got done=%b wait=%0d expected 10/4", done, n);
    end
    vec_cnt++;
    if (result_data !== W'(20)) begin
      err_cnt++; $display("FAIL drain_result: got %0d expected 20", result_data);
    end
    req  = '0;
    spur = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      vec_cnt++;
      if ({done, grant, busy} !== 5'b0 || result_data !== W'(20)) begin
        err_cnt++;
        $display("FAIL drain_spurious%0d: got done=%b grant=%b busy=%b result=%0d expected 0/0/0/20",
                 c, done, grant, busy, result_data);
      end
    end
    spur = 1'b0;
    repeat (4) @(negedge clk);
    mac_lat = 1;
  endtask

  task automatic test_abort();
    int n;
    req = 2'b01;
    @(negedge clk);
    vec_cnt++;
    if (grant !== 2'b01) begin
      err_cnt++; $display("FAIL abort_grant: got %b expected 01", grant);
    end
    for (int i = 0; i < 2; i++) begin
      op_a[0 +: W] = W'(9); op_b[0 +: W] = W'(1); op_valid = 2'b01;
      @(negedge clk);
    end
    rst = 1'b1; req = '0; op_valid = '0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      vec_cnt++;
      if ({grant, done, busy, mac_valid_out} !== 6'b0) begin
        err_cnt++;
        $display("FAIL abort_in_reset%0d: got %b expected 0", c, {grant, done, busy, mac_valid_out});
      end
    end
    rst = 1'b0;
    @(negedge clk);
    vec_cnt++;
    if ({mac_reset, done} !== 3'b100) begin
      err_cnt++; $display("FAIL abort_clr: got %b expected 100", {mac_reset, done});
    end
    req = 2'b10;
    @(negedge clk);
    vec_cnt++;
    if ({mac_reset, done} !== 3'b000) begin
      err_cnt++; $display("FAIL abort_idle: got %b expected 000", {mac_reset, done});
    end
    @(negedge clk);
    vec_cnt++;
    if (grant !== 2'b10) begin
      err_cnt++; $display("FAIL abort_regrant: got %b expected 10", grant);
    end
    for (int i = 0; i < 4; i++) begin
      op_a[W +: W] = W'(7); op_b[W +: W] = W'(1); op_valid = 2'b10;
      @(negedge clk);
    end
    op_valid = '0;
    n = 0;
    while (done == '0 && n < 20) begin @(negedge clk); n++; end
    vec_cnt++;
    if (done !== 2'b10 || result_data !== W'(28) || n !== 2) begin
      err_cnt++;
      $display("FAIL abort_next_job: got done=%b result=%0d wait=%0d expected 10/28/2",
               done, result_data, n);
    end
    req = '0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single_job();
    test_two_req();
    test_toggle();
    test_drain();
    test_abort();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "simulation time limit reached");
  end

endmodule
